seg_sev_driver_io: RTL and testbench



---
 rtl/seg_sev_driver_io_pkg.sv | 29 ++
 rtl/seg7_decoder.sv | 43 ++++
 rtl/seg_sev_driver_io.sv | 158 +++++++++++++++
 tb/tb_seg_sev_driver_io.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_sev_driver_io_pkg.sv
// -----------------------------------------------------------------------------
// seg_sev_driver_io_pkg
// Shared constants for the four-digit seven-segment bus peripheral: default
// bus base address, register offsets within the bank, register count, the
// blank segment pattern and a helper that turns a digit index into an
// active-low anode mask.
// -----------------------------------------------------------------------------
package seg_sev_driver_io_pkg;

  localparam logic [7:0] BASE_ADDR_DEFAULT = 8'hD0;

  // Register offsets relative to BASE_ADDR.
  localparam logic [1:0] REG_RIGHT = 2'd0;  // digits 1:0
  localparam logic [1:0] REG_LEFT  = 2'd1;  // digits 3:2
  localparam logic [1:0] REG_DOT   = 2'd2;  // decimal points

  localparam int NUM_REGS = 3;

  // All segments and the dot off (outputs are active low).
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low anode mask with a single 0 at the selected digit.
  function automatic logic [3:0] digit_anode(input logic [1:0] idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Combinational hex-to-seven-segment decoder with active-low outputs.
//   i_hex [3:0] : nibble to display (0-F)
//   i_dot       : 1 lights the decimal point
//   o_seg [7:0] : {dp, g, f, e, d, c, b, a}, all active low
// -----------------------------------------------------------------------------
module seg7_decoder
  import seg_sev_driver_io_pkg::*;
(
  input  logic [3:0] i_hex,
  input  logic       i_dot,
  output logic [7:0] o_seg
);

  logic [6:0] w_seg7;

  always_comb begin
    w_seg7 = SEG_BLANK[6:0];
    case (i_hex)
      4'h0: w_seg7 = 7'b1000000;
      4'h1: w_seg7 = 7'b1111001;
      4'h2: w_seg7 = 7'b0100100;
      4'h3: w_seg7 = 7'b0110000;
      4'h4: w_seg7 = 7'b0011001;
      4'h5: w_seg7 = 7'b0010010;
      4'h6: w_seg7 = 7'b0000010;
      4'h7: w_seg7 = 7'b1111000;
      4'h8: w_seg7 = 7'b0000000;
      4'h9: w_seg7 = 7'b0010000;
      4'hA: w_seg7 = 7'b0001000;
      4'hB: w_seg7 = 7'b0000011;
      4'hC: w_seg7 = 7'b1000110;
      4'hD: w_seg7 = 7'b0100001;
      4'hE: w_seg7 = 7'b0000110;
      4'hF: w_seg7 = 7'b0001110;
      default: w_seg7 = SEG_BLANK[6:0];
    endcase
  end

  assign o_seg = {~i_dot, w_seg7};

endmodule

// File: rtl/seg_sev_driver_io.sv
// -----------------------------------------------------------------------------
// seg_sev_driver_io
// Memory-mapped four-digit seven-segment display peripheral on a shared 8-bit
// tristate bus. Three byte registers at BASE_ADDR..BASE_ADDR+2 hold the right
// digit pair, the left digit pair and the decimal points; the stored digits
// are time-multiplexed onto the board's active-low anodes and segments.
//
// Ports:
//   CLK             system clock, rising edge
//   RESET           synchronous, active-high reset
//   BUS_DATA  [7:0] shared data bus (inout), driven only for reads
//   BUS_ADDR  [7:0] bus address
//   BUS_WE          1 = master writes, 0 = master may read
//   SEG_SELECT[3:0] digit anodes, active low, bit 0 = rightmost digit
//   DEC_OUT   [7:0] segments, active low, {dp, g, f, e, d, c, b, a}
//
// Bus protocol: a transfer is qualified purely by an in-range BUS_ADDR at a
// rising edge. With BUS_WE=1 the addressed register loads BUS_DATA at that
// edge. With BUS_WE=0 the register is captured at that edge and driven onto
// BUS_DATA from then on for as long as the address stays in range with
// BUS_WE=0; the drive enable is additionally gated by BUS_WE so the block
// lets go of the bus the moment the master starts a write.
// -----------------------------------------------------------------------------
module seg_sev_driver_io
  import seg_sev_driver_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          REFRESH_DIV = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic [3:0] SEG_SELECT,
  output logic [7:0] DEC_OUT
);

  localparam int                CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  // ---------------------------------------------------------------------------
  // Address decode. The offset subtraction wraps modulo 256, so a single
  // unsigned compare covers both "below base" and "above base+2".
  // ---------------------------------------------------------------------------
  logic [7:0] w_offset;
  logic       w_in_range;

  assign w_offset   = BUS_ADDR - BASE_ADDR;
  assign w_in_range = (w_offset < 8'(NUM_REGS));

  // ---------------------------------------------------------------------------
  // Register bank and read capture
  // ---------------------------------------------------------------------------
  logic [7:0] r_reg_right;
  logic [7:0] r_reg_left;
  logic [7:0] r_reg_dot;
  logic [7:0] r_out_byte;
  logic       r_out_we;
  logic [7:0] w_rd_byte;

  always_comb begin
    w_rd_byte = 8'h00;
    case (w_offset[1:0])
      REG_RIGHT: w_rd_byte = r_reg_right;
      REG_LEFT:  w_rd_byte = r_reg_left;
      REG_DOT:   w_rd_byte = r_reg_dot;
      default:   w_rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_reg_right <= 8'h00;
      r_reg_left  <= 8'h00;
      r_reg_dot   <= 8'h00;
      r_out_byte  <= 8'h00;
      r_out_we    <= 1'b0;
    end else begin
      if (BUS_WE && w_in_range) begin
        case (w_offset[1:0])
          REG_RIGHT: r_reg_right <= BUS_DATA;
          REG_LEFT:  r_reg_left  <= BUS_DATA;
          REG_DOT:   r_reg_dot   <= BUS_DATA;
          default:   ;
        endcase
      end
      r_out_we   <= !BUS_WE && w_in_range;
      r_out_byte <= w_rd_byte;
    end
  end

  assign BUS_DATA = (r_out_we && !BUS_WE) ? r_out_byte : 8'hZZ;

  // ---------------------------------------------------------------------------
  // Refresh timing: each digit slot lasts REFRESH_DIV cycles.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_refresh_cnt;
  logic [1:0]       r_digit_idx;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= 2'd0;
    end else if (r_refresh_cnt == CNT_MAX) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= r_digit_idx + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit mux and segment decode
  // ---------------------------------------------------------------------------
  logic [3:0] w_nibble;
  logic       w_dot;
  logic [7:0] w_seg;

  always_comb begin
    w_nibble = 4'h0;
    case (r_digit_idx)
      2'd0:    w_nibble = r_reg_right[3:0];
      2'd1:    w_nibble = r_reg_right[7:4];
      2'd2:    w_nibble = r_reg_left[3:0];
      2'd3:    w_nibble = r_reg_left[7:4];
      default: w_nibble = 4'h0;
    endcase
  end

  // Only dot bits [3:0] reach the display; [7:4] are storage only.
  assign w_dot = r_reg_dot[r_digit_idx];

  seg7_decoder u_seg7_decoder (
    .i_hex (w_nibble),
    .i_dot (w_dot),
    .o_seg (w_seg)
  );

  // Registered display outputs; blank while in reset so the first visible
  // frame is digit 0 one edge after reset releases.
  logic [3:0] r_seg_select;
  logic [7:0] r_dec_out;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_seg_select <= 4'b1111;
      r_dec_out    <= SEG_BLANK;
    end else begin
      r_seg_select <= digit_anode(r_digit_idx);
      r_dec_out    <= w_seg;
    end
  end

  assign SEG_SELECT = r_seg_select;
  assign DEC_OUT    = r_dec_out;

endmodule

// File: tb/tb_seg_sev_driver_io.sv
// -----------------------------------------------------------------------------
// tb_seg_sev_driver_io
// Directed bench for seg_sev_driver_io (REFRESH_DIV=4). Driver tasks push the
// expected bus or display value, tagged with the clock edge count at which it
// must be visible, into exp_q; the monitor pops and compares on falling edges.
// A pullup on the bus makes a released bus read as 8'hFF.
// -----------------------------------------------------------------------------
module tb_seg_sev_driver_io;

  localparam int         DIV   = 4;
  localparam logic [3:0] K_BUS = 4'd0;
  localparam logic [3:0] K_DSP = 4'd1;
  localparam logic [7:0] BUS_Z = 8'hFF;  // pulled-up released bus

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic       tb_drive;
  logic [7:0] tb_wdata;
  wire  [7:0] bus_data;
  logic [3:0] seg_select;
  logic [7:0] dec_out;

  always #5 clk = ~clk;

  assign bus_data = tb_drive ? tb_wdata : 8'hzz;
  pullup (bus_data);

  seg_sev_driver_io #(
    .BASE_ADDR   (8'hD0),
    .REFRESH_DIV (DIV)
  ) dut (
    .CLK        (clk),
    .RESET      (reset),
    .BUS_DATA   (bus_data),
    .BUS_ADDR   (bus_addr),
    .BUS_WE     (bus_we),
    .SEG_SELECT (seg_select),
    .DEC_OUT    (dec_out)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard: entry = {edge count[23:0], kind[3:0], value[11:0]}
  // ---------------------------------------------------------------------------
  logic [39:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [39:0] mon_e;
  logic [11:0] mon_act;

  task automatic push_exp(input int unsigned at, input logic [3:0] kind, input logic [11:0] val);
    logic [31:0] at_v;
    at_v = at;
    exp_q.push_back({at_v[23:0], kind, val});
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0][39:16] <= cyc[23:0]) begin
      mon_e = exp_q.pop_front();
      total++;
      if (mon_e[15:12] == K_BUS) mon_act = {4'h0, bus_data};
      else                       mon_act = {seg_select, dec_out};
      if (mon_e[39:16] != cyc[23:0]) begin
        bad++;
        $display("FAIL missed_check kind=%0d due=%0d now=%0d", mon_e[15:12], mon_e[39:16], cyc);
      end else if (mon_act !== mon_e[11:0]) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h want=%h",
                 (mon_e[15:12] == K_BUS) ? "bus_data" : "display{sel,dec}",
                 cyc, mon_act, mon_e[11:0]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change 1 ns after a falling edge
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    bus_addr = addr;
    tb_wdata = data;
    tb_drive = 1'b1;
    bus_we   = 1'b1;
    // Only the bench may be driving here; any DUT drive would corrupt this.
    push_exp(cyc + 1, K_BUS, {4'h0, data});
    tick();
    bus_we   = 1'b0;
    tb_drive = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] addr, input logic [7:0] exp_v);
    bus_addr = addr;
    bus_we   = 1'b0;
    push_exp(cyc + 1, K_BUS, {4'h0, exp_v});
    tick();
  endtask

  // Expected display per digit index for registers 21 / 43 / 05.
  logic [11:0] disp_tab [4];

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int unsigned r_edge;
    disp_tab[0] = {4'b1110, 8'h79};  // "1", dot on
    disp_tab[1] = {4'b1101, 8'hA4};  // "2", dot off
    disp_tab[2] = {4'b1011, 8'h30};  // "3", dot on
    disp_tab[3] = {4'b0111, 8'h99};  // "4", dot off

    reset    = 1'b1;
    bus_we   = 1'b0;
    bus_addr = 8'h00;
    tb_drive = 1'b0;
    tb_wdata = 8'h00;

    // Reset then idle: blank display, released bus, even with a read address.
    tick();
    push_exp(cyc + 1, K_DSP, {4'b1111, 8'hFF});
    push_exp(cyc + 1, K_BUS, {4'h0, BUS_Z});
    tick();
    bus_addr = 8'hD0;
    push_exp(cyc + 1, K_DSP, {4'b1111, 8'hFF});
    push_exp(cyc + 1, K_BUS, {4'h0, BUS_Z});
    tick();
    reset = 1'b0;

    // Registers come out of reset as zero.
    bus_read(8'hD0, 8'h00);
    bus_read(8'hD1, 8'h00);
    bus_read(8'hD2, 8'h00);

    // Writes then read-back.
    bus_write(8'hD0, 8'h0F);
    bus_write(8'hD1, 8'hF0);
    bus_write(8'hD2, 8'h0F);
    bus_read(8'hD0, 8'h0F);
    bus_read(8'hD1, 8'hF0);
    bus_read(8'hD2, 8'h0F);
    bus_read(8'h00, BUS_Z);

    // Out-of-range writes and reads.
    bus_write(8'hD3, 8'hAA);
    bus_write(8'h00, 8'hAA);
    bus_read(8'hD0, 8'h0F);
    bus_read(8'hD1, 8'hF0);
    bus_read(8'hD2, 8'h0F);
    bus_read(8'hD3, BUS_Z);
    bus_read(8'hCF, BUS_Z);

    // Held read address keeps the data on the bus.
    bus_read(8'hD1, 8'hF0);
    bus_read(8'hD1, 8'hF0);
    bus_read(8'hD1, 8'hF0);

    // Read right after a write to the same address sees the new value.
    bus_write(8'hD0, 8'h5A);
    bus_read(8'hD0, 8'h5A);
    bus_write(8'hD2, 8'hC3);
    bus_read(8'hD2, 8'hC3);
    bus_read(8'h00, BUS_Z);

    // Display: reset to align the refresh counter, then load 21 / 43 / 05.
    reset    = 1'b1;
    bus_addr = 8'h00;
    tick();
    reset  = 1'b0;
    r_edge = cyc + 1;  // first non-blank frame
    push_exp(r_edge, K_DSP, {4'b1110, 8'hC0});  // digit 0 of cleared regs
    bus_write(8'hD0, 8'h21);
    bus_write(8'hD1, 8'h43);
    bus_write(8'hD2, 8'h05);
    bus_addr = 8'h00;
    for (int n = 3; n <= 20; n++) begin
      push_exp(r_edge + n, K_DSP, disp_tab[(n / DIV) % 4]);
    end
    repeat (18) tick();

    // Reset in the middle of a held read while the display runs.
    bus_read(8'hD0, 8'h21);
    bus_read(8'hD0, 8'h21);
    reset = 1'b1;
    push_exp(cyc + 1, K_BUS, {4'h0, BUS_Z});
    push_exp(cyc + 1, K_DSP, {4'b1111, 8'hFF});
    tick();
    reset = 1'b0;
    push_exp(cyc + 1, K_BUS, {4'h0, 8'h00});
    push_exp(cyc + 1, K_DSP, {4'b1110, 8'hC0});
    tick();
    bus_read(8'hD2, 8'h00);
    bus_read(8'h00, BUS_Z);

    repeat (2) tick();
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL unchecked_entry due=%0d now=%0d", mon_e[39:16], cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
